// File: rtl/reservation_entry_param_pkg.sv
// Shared state encoding and default sizing for the parametrised reservation entry.
package rs_entry_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        WAIT   = 2'd1,
        ISSUED = 2'd2
    } state_t;

    localparam int DEF_SRC     = 2;
    localparam int DEF_CDB     = 3;
    localparam int DEF_DATA    = 32;
    localparam int DEF_TAG     = 6;
    localparam int DEF_PTR     = 4;
    localparam int DEF_PAYLOAD = 64;

endpackage

// File: rtl/reservation_entry_wakeup.sv
// CDB snoop for one operand: compares its tag against every channel and
// returns the result of the lowest-index writeback hit.
module reservation_entry_wakeup #(
    parameter int P_CDB  = 3,
    parameter int P_TAG  = 6,
    parameter int P_DATA = 32
) (
    input  logic [P_TAG-1:0]        tag,
    input  logic [P_CDB-1:0]        cdb_valid,
    input  logic [P_CDB-1:0]        cdb_writeback,
    input  logic [P_CDB*P_TAG-1:0]  cdb_regname,
    input  logic [P_CDB*P_DATA-1:0] cdb_data,
    output logic                    hit,
    output logic [P_DATA-1:0]       data
);

    // Scan from the highest index down so the lowest-index hit is the last to win.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int c = P_CDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_writeback[c] &&
                (cdb_regname[c*P_TAG +: P_TAG] == tag)) begin
                hit  = 1'b1;
                data = cdb_data[c*P_DATA +: P_DATA];
            end
        end
    end

endmodule

// File: rtl/reservation_entry_param.sv
// One reservation-station slot: holds an instruction until its operands and
// in-order pointer are ready, then tracks it through issue, completion or replay.
module reservation_entry_param
    import rs_entry_pkg::*;
#(
    parameter int P_SRC     = DEF_SRC,
    parameter int P_CDB     = DEF_CDB,
    parameter int P_DATA    = DEF_DATA,
    parameter int P_TAG     = DEF_TAG,
    parameter int P_PTR     = DEF_PTR,
    parameter int P_PAYLOAD = DEF_PAYLOAD
) (
    input  logic                    iCLOCK,
    input  logic                    inRESET,
    input  logic                    iREMOVE_VALID,
    input  logic                    iREGISTER_VALID,
    input  logic [P_PAYLOAD-1:0]    iREGISTER_PAYLOAD,
    input  logic [P_SRC-1:0]        iREGISTER_SRC_VALID,
    input  logic [P_SRC-1:0]        iREGISTER_SRC_SYSREG,
    input  logic [P_SRC*P_DATA-1:0] iREGISTER_SRC_DATA,
    input  logic [P_TAG-1:0]        iREGISTER_DEST_REGNAME,
    input  logic [5:0]              iREGISTER_COMMIT_TAG,
    input  logic [P_PTR-1:0]        iREGISTER_EX_POINTER,
    input  logic [P_CDB-1:0]        iCDB_VALID,
    input  logic [P_CDB-1:0]        iCDB_WRITEBACK,
    input  logic [P_CDB*P_TAG-1:0]  iCDB_REGNAME,
    input  logic [P_CDB*P_DATA-1:0] iCDB_DATA,
    input  logic [P_PTR-1:0]        iEX_EXECUTION_POINTER,
    input  logic                    iISSUE,
    input  logic                    iEX_DONE,
    input  logic                    iEX_REPLAY,
    output logic                    oINFO_ENTRY_VALID,
    output logic                    oINFO_MATCHING,
    output logic                    oINFO_ISSUED,
    output logic [P_SRC-1:0]        oINFO_SRC_VALID,
    output logic [P_SRC-1:0]        oINFO_SRC_SYSREG,
    output logic [P_SRC*P_DATA-1:0] oINFO_SRC_DATA,
    output logic [P_PAYLOAD-1:0]    oINFO_PAYLOAD,
    output logic [P_TAG-1:0]        oINFO_DEST_REGNAME,
    output logic [5:0]              oINFO_COMMIT_TAG
);

    state_t                  state;
    logic [P_SRC-1:0]        src_valid;
    logic [P_SRC-1:0]        src_sysreg;
    logic [P_SRC*P_DATA-1:0] src_data;
    logic [P_PAYLOAD-1:0]    payload;
    logic [P_TAG-1:0]        dest_regname;
    logic [5:0]              commit_tag;
    logic [P_PTR-1:0]        ex_pointer;
    logic                    ptr_match;

    logic [P_SRC-1:0]        hit;
    logic [P_SRC*P_DATA-1:0] hit_data;
    logic                    matching;

    // The same comparator serves allocation (incoming tag) and WAIT (stored tag).
    for (genvar i = 0; i < P_SRC; i++) begin : g_wakeup
        logic [P_TAG-1:0] tag_sel;

        assign tag_sel = (state == EMPTY) ? iREGISTER_SRC_DATA[i*P_DATA +: P_TAG]
                                          : src_data[i*P_DATA +: P_TAG];

        reservation_entry_wakeup #(
            .P_CDB (P_CDB),
            .P_TAG (P_TAG),
            .P_DATA(P_DATA)
        ) u_wakeup (
            .tag          (tag_sel),
            .cdb_valid    (iCDB_VALID),
            .cdb_writeback(iCDB_WRITEBACK),
            .cdb_regname  (iCDB_REGNAME),
            .cdb_data     (iCDB_DATA),
            .hit          (hit[i]),
            .data         (hit_data[i*P_DATA +: P_DATA])
        );
    end

    assign matching = (state == WAIT) && (&src_valid) && ptr_match;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state        <= EMPTY;
            src_valid    <= '0;
            src_sysreg   <= '0;
            src_data     <= '0;
            payload      <= '0;
            dest_regname <= '0;
            commit_tag   <= '0;
            ex_pointer   <= '0;
            ptr_match    <= 1'b0;
        end else if (iREMOVE_VALID || (state == ISSUED && iEX_DONE)) begin
            state        <= EMPTY;
            src_valid    <= '0;
            src_sysreg   <= '0;
            src_data     <= '0;
            payload      <= '0;
            dest_regname <= '0;
            commit_tag   <= '0;
            ex_pointer   <= '0;
            ptr_match    <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (iREGISTER_VALID) begin
                        state        <= WAIT;
                        payload      <= iREGISTER_PAYLOAD;
                        dest_regname <= iREGISTER_DEST_REGNAME;
                        commit_tag   <= iREGISTER_COMMIT_TAG;
                        src_sysreg   <= iREGISTER_SRC_SYSREG;
                        ex_pointer   <= iREGISTER_EX_POINTER;
                        ptr_match    <= (iREGISTER_EX_POINTER == iEX_EXECUTION_POINTER);
                        for (int i = 0; i < P_SRC; i++) begin
                            if (iREGISTER_SRC_SYSREG[i] || iREGISTER_SRC_VALID[i]) begin
                                src_valid[i]                <= 1'b1;
                                src_data[i*P_DATA +: P_DATA] <= iREGISTER_SRC_DATA[i*P_DATA +: P_DATA];
                            end else if (hit[i]) begin
                                src_valid[i]                <= 1'b1;
                                src_data[i*P_DATA +: P_DATA] <= hit_data[i*P_DATA +: P_DATA];
                            end else begin
                                src_valid[i]                <= 1'b0;
                                src_data[i*P_DATA +: P_DATA] <= iREGISTER_SRC_DATA[i*P_DATA +: P_DATA];
                            end
                        end
                    end
                end
                WAIT: begin
                    for (int i = 0; i < P_SRC; i++) begin
                        if (!src_valid[i] && hit[i]) begin
                            src_valid[i]                <= 1'b1;
                            src_data[i*P_DATA +: P_DATA] <= hit_data[i*P_DATA +: P_DATA];
                        end
                    end
                    if (ex_pointer == iEX_EXECUTION_POINTER) begin
                        ptr_match <= 1'b1;
                    end
                    if (iISSUE && matching) begin
                        state <= ISSUED;
                    end
                end
                ISSUED: begin
                    if (iEX_REPLAY) begin
                        state <= WAIT;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign oINFO_ENTRY_VALID  = (state != EMPTY);
    assign oINFO_MATCHING     = matching;
    assign oINFO_ISSUED       = (state == ISSUED);
    assign oINFO_SRC_VALID    = src_valid;
    assign oINFO_SRC_SYSREG   = src_sysreg;
    assign oINFO_SRC_DATA     = src_data;
    assign oINFO_PAYLOAD      = payload;
    assign oINFO_DEST_REGNAME = dest_regname;
    assign oINFO_COMMIT_TAG   = commit_tag;

endmodule

// File: tb/tb_reservation_entry_param.sv
// Directed bench for reservation_entry_param; expectations are queued with the
// stimulus and popped when the entry's registered outputs are sampled.
module tb_reservation_entry_param;

    localparam int P_SRC     = 2;
    localparam int P_CDB     = 3;
    localparam int P_DATA    = 32;
    localparam int P_TAG     = 6;
    localparam int P_PTR     = 4;
    localparam int P_PAYLOAD = 64;
    localparam int W         = 3 + 2 + 2 + 64 + 64 + 6 + 6;

    logic                    iCLOCK;
    logic                    inRESET;
    logic                    iREMOVE_VALID;
    logic                    iREGISTER_VALID;
    logic [P_PAYLOAD-1:0]    iREGISTER_PAYLOAD;
    logic [P_SRC-1:0]        iREGISTER_SRC_VALID;
    logic [P_SRC-1:0]        iREGISTER_SRC_SYSREG;
    logic [P_SRC*P_DATA-1:0] iREGISTER_SRC_DATA;
    logic [P_TAG-1:0]        iREGISTER_DEST_REGNAME;
    logic [5:0]              iREGISTER_COMMIT_TAG;
    logic [P_PTR-1:0]        iREGISTER_EX_POINTER;
    logic [P_CDB-1:0]        iCDB_VALID;
    logic [P_CDB-1:0]        iCDB_WRITEBACK;
    logic [P_CDB*P_TAG-1:0]  iCDB_REGNAME;
    logic [P_CDB*P_DATA-1:0] iCDB_DATA;
    logic [P_PTR-1:0]        iEX_EXECUTION_POINTER;
    logic                    iISSUE;
    logic                    iEX_DONE;
    logic                    iEX_REPLAY;
    logic                    oINFO_ENTRY_VALID;
    logic                    oINFO_MATCHING;
    logic                    oINFO_ISSUED;
    logic [P_SRC-1:0]        oINFO_SRC_VALID;
    logic [P_SRC-1:0]        oINFO_SRC_SYSREG;
    logic [P_SRC*P_DATA-1:0] oINFO_SRC_DATA;
    logic [P_PAYLOAD-1:0]    oINFO_PAYLOAD;
    logic [P_TAG-1:0]        oINFO_DEST_REGNAME;
    logic [5:0]              oINFO_COMMIT_TAG;

    typedef struct {
        string          name;
        logic [W-1:0]   v;
    } exp_t;

    exp_t         sb[$];
    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] observed;

    localparam logic [63:0] PL1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PL2 = 64'hA5A5_5A5A_F00D_BEEF;
    localparam logic [63:0] PL3 = 64'h1111_2222_3333_4444;

    reservation_entry_param #(
        .P_SRC(P_SRC), .P_CDB(P_CDB), .P_DATA(P_DATA),
        .P_TAG(P_TAG), .P_PTR(P_PTR), .P_PAYLOAD(P_PAYLOAD)
    ) dut (
        .iCLOCK                (iCLOCK),
        .inRESET               (inRESET),
        .iREMOVE_VALID         (iREMOVE_VALID),
        .iREGISTER_VALID       (iREGISTER_VALID),
        .iREGISTER_PAYLOAD     (iREGISTER_PAYLOAD),
        .iREGISTER_SRC_VALID   (iREGISTER_SRC_VALID),
        .iREGISTER_SRC_SYSREG  (iREGISTER_SRC_SYSREG),
        .iREGISTER_SRC_DATA    (iREGISTER_SRC_DATA),
        .iREGISTER_DEST_REGNAME(iREGISTER_DEST_REGNAME),
        .iREGISTER_COMMIT_TAG  (iREGISTER_COMMIT_TAG),
        .iREGISTER_EX_POINTER  (iREGISTER_EX_POINTER),
        .iCDB_VALID            (iCDB_VALID),
        .iCDB_WRITEBACK        (iCDB_WRITEBACK),
        .iCDB_REGNAME          (iCDB_REGNAME),
        .iCDB_DATA             (iCDB_DATA),
        .iEX_EXECUTION_POINTER (iEX_EXECUTION_POINTER),
        .iISSUE                (iISSUE),
        .iEX_DONE              (iEX_DONE),
        .iEX_REPLAY            (iEX_REPLAY),
        .oINFO_ENTRY_VALID     (oINFO_ENTRY_VALID),
        .oINFO_MATCHING        (oINFO_MATCHING),
        .oINFO_ISSUED          (oINFO_ISSUED),
        .oINFO_SRC_VALID       (oINFO_SRC_VALID),
        .oINFO_SRC_SYSREG      (oINFO_SRC_SYSREG),
        .oINFO_SRC_DATA        (oINFO_SRC_DATA),
        .oINFO_PAYLOAD         (oINFO_PAYLOAD),
        .oINFO_DEST_REGNAME    (oINFO_DEST_REGNAME),
        .oINFO_COMMIT_TAG      (oINFO_COMMIT_TAG)
    );

    assign observed = {oINFO_ENTRY_VALID, oINFO_MATCHING, oINFO_ISSUED,
                       oINFO_SRC_VALID, oINFO_SRC_SYSREG, oINFO_SRC_DATA,
                       oINFO_PAYLOAD, oINFO_DEST_REGNAME, oINFO_COMMIT_TAG};

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] exp_vec(input logic v, input logic m, input logic iss,
                                             input logic [1:0] sv, input logic [1:0] ss,
                                             input logic [31:0] d1, input logic [31:0] d0,
                                             input logic [63:0] pl, input logic [5:0] dst,
                                             input logic [5:0] cmt);
        return {v, m, iss, sv, ss, d1, d0, pl, dst, cmt};
    endfunction

    task automatic expect_out(input string name, input logic [W-1:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        sb.push_back(e);
    endtask

    task automatic check_output();
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard: observed %h, expected a queued entry", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.v) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %h expected %h", e.name, observed, e.v);
            end
        end
    endtask

    task automatic idle();
        iREGISTER_VALID = 1'b0;
        iCDB_VALID      = '0;
        iCDB_WRITEBACK  = '0;
        iISSUE          = 1'b0;
        iEX_DONE        = 1'b0;
        iEX_REPLAY      = 1'b0;
        iREMOVE_VALID   = 1'b0;
    endtask

    task automatic set_cdb(input int ch, input logic [5:0] tag, input logic [31:0] data,
                           input logic wb);
        iCDB_VALID[ch]          = 1'b1;
        iCDB_WRITEBACK[ch]      = wb;
        iCDB_REGNAME[ch*6 +: 6]  = tag;
        iCDB_DATA[ch*32 +: 32]  = data;
    endtask

    task automatic step();
        @(posedge iCLOCK);
        #1;
        check_output();
        idle();
    endtask

    initial begin
        idle();
        inRESET                = 1'b0;
        iREGISTER_PAYLOAD      = '0;
        iREGISTER_SRC_VALID    = '0;
        iREGISTER_SRC_SYSREG   = '0;
        iREGISTER_SRC_DATA     = '0;
        iREGISTER_DEST_REGNAME = '0;
        iREGISTER_COMMIT_TAG   = '0;
        iREGISTER_EX_POINTER   = '0;
        iCDB_REGNAME           = '0;
        iCDB_DATA              = '0;
        iEX_EXECUTION_POINTER  = '0;

        #3;
        expect_out("reset", '0);
        check_output();
        @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;

        // Partial allocate, late CDB wakeup, issue / replay / done+replay
        iREGISTER_VALID        = 1'b1;
        iREGISTER_PAYLOAD      = PL1;
        iREGISTER_SRC_VALID    = 2'b01;
        iREGISTER_SRC_DATA     = {32'h0000_0005, 32'h0000_1234};
        iREGISTER_DEST_REGNAME = 6'h11;
        iREGISTER_COMMIT_TAG   = 6'h22;
        iREGISTER_EX_POINTER   = 4'd0;
        iEX_EXECUTION_POINTER  = 4'd0;
        expect_out("alloc_partial", exp_vec(1, 0, 0, 2'b01, 2'b00, 32'h5, 32'h1234, PL1, 6'h11, 6'h22));
        step();

        iREGISTER_VALID        = 1'b1;
        iREGISTER_PAYLOAD      = '1;
        iREGISTER_SRC_VALID    = 2'b11;
        iREGISTER_SRC_DATA     = {32'hDEAD_0000, 32'hBEEF_0000};
        iREGISTER_DEST_REGNAME = 6'h3F;
        expect_out("register_ignored_in_wait", exp_vec(1, 0, 0, 2'b01, 2'b00, 32'h5, 32'h1234, PL1, 6'h11, 6'h22));
        step();

        set_cdb(2, 6'h05, 32'h0000_CAFE, 1'b1);
        expect_out("cdb_ch2_wakeup", exp_vec(1, 1, 0, 2'b11, 2'b00, 32'hCAFE, 32'h1234, PL1, 6'h11, 6'h22));
        step();

        iISSUE = 1'b1;
        expect_out("issue", exp_vec(1, 0, 1, 2'b11, 2'b00, 32'hCAFE, 32'h1234, PL1, 6'h11, 6'h22));
        step();

        iEX_REPLAY = 1'b1;
        expect_out("replay", exp_vec(1, 1, 0, 2'b11, 2'b00, 32'hCAFE, 32'h1234, PL1, 6'h11, 6'h22));
        step();

        iISSUE = 1'b1;
        expect_out("reissue", exp_vec(1, 0, 1, 2'b11, 2'b00, 32'hCAFE, 32'h1234, PL1, 6'h11, 6'h22));
        step();

        iEX_DONE   = 1'b1;
        iEX_REPLAY = 1'b1;
        expect_out("done_and_replay", '0);
        step();

        // Same-cycle wakeup with two hitting channels; sysreg operand must not snoop
        iREGISTER_VALID        = 1'b1;
        iREGISTER_PAYLOAD      = PL2;
        iREGISTER_SRC_VALID    = 2'b00;
        iREGISTER_SRC_SYSREG   = 2'b10;
        iREGISTER_SRC_DATA     = {32'h0000_0009, 32'h0000_0007};
        iREGISTER_DEST_REGNAME = 6'h2A;
        iREGISTER_COMMIT_TAG   = 6'h15;
        iREGISTER_EX_POINTER   = 4'd2;
        iEX_EXECUTION_POINTER  = 4'd2;
        set_cdb(0, 6'h07, 32'h0000_000A, 1'b1);
        set_cdb(1, 6'h07, 32'h0000_000B, 1'b1);
        set_cdb(2, 6'h09, 32'h0000_DEAD, 1'b1);
        expect_out("alloc_same_cycle_wakeup", exp_vec(1, 1, 0, 2'b11, 2'b10, 32'h9, 32'hA, PL2, 6'h2A, 6'h15));
        step();

        iREMOVE_VALID = 1'b1;
        iISSUE        = 1'b1;
        expect_out("remove_with_issue", '0);
        step();

        // Writeback gating and the in-order pointer
        iREGISTER_VALID        = 1'b1;
        iREGISTER_PAYLOAD      = PL3;
        iREGISTER_SRC_VALID    = 2'b10;
        iREGISTER_SRC_SYSREG   = 2'b00;
        iREGISTER_SRC_DATA     = {32'h0000_0055, 32'h0000_000C};
        iREGISTER_DEST_REGNAME = 6'h01;
        iREGISTER_COMMIT_TAG   = 6'h3E;
        iREGISTER_EX_POINTER   = 4'd3;
        iEX_EXECUTION_POINTER  = 4'd1;
        expect_out("alloc_ptr_ahead", exp_vec(1, 0, 0, 2'b10, 2'b00, 32'h55, 32'h0C, PL3, 6'h01, 6'h3E));
        step();

        set_cdb(0, 6'h0C, 32'h0000_0077, 1'b0);
        expect_out("cdb_no_writeback", exp_vec(1, 0, 0, 2'b10, 2'b00, 32'h55, 32'h0C, PL3, 6'h01, 6'h3E));
        step();

        set_cdb(1, 6'h0C, 32'h0000_0088, 1'b1);
        expect_out("cdb_ch1_wakeup", exp_vec(1, 0, 0, 2'b11, 2'b00, 32'h55, 32'h88, PL3, 6'h01, 6'h3E));
        step();

        iEX_EXECUTION_POINTER = 4'd2;
        iISSUE                = 1'b1;
        expect_out("issue_not_ready", exp_vec(1, 0, 0, 2'b11, 2'b00, 32'h55, 32'h88, PL3, 6'h01, 6'h3E));
        step();

        iEX_EXECUTION_POINTER = 4'd3;
        expect_out("ptr_reached", exp_vec(1, 1, 0, 2'b11, 2'b00, 32'h55, 32'h88, PL3, 6'h01, 6'h3E));
        step();

        iEX_EXECUTION_POINTER = 4'd4;
        expect_out("ptr_moved_on", exp_vec(1, 1, 0, 2'b11, 2'b00, 32'h55, 32'h88, PL3, 6'h01, 6'h3E));
        step();

        iISSUE = 1'b1;
        expect_out("issue_ptr_entry", exp_vec(1, 0, 1, 2'b11, 2'b00, 32'h55, 32'h88, PL3, 6'h01, 6'h3E));
        step();

        #2;
        inRESET = 1'b0;
        #1;
        expect_out("async_reset_in_issued", '0);
        check_output();
        @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;

        expect_out("idle_after_reset", '0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
